// File: rtl/gpio_irq.sv
// gpio_irq: memory-mapped GPIO bank with pad modes, SET/CLR, synchronised
// inputs and rise/fall edge interrupts with W1C pending bits.
//
// Ports:
//   clk, reset_n      clock, async active-low reset
//   select, wstrb     bus request (held until ready), byte strobes (0 = read)
//   addr, data_i      byte offset, write data
//   ready, data_o     one-cycle completion pulse, read data while ready=1
//   gpio              pads (inout)
//   gpio_af_in        alternate-function drive for bridge-mode pins
//   gpio_af_out       pad value for bridge-mode pins, else 0
//   irq               OR of all pending bits
module gpio_irq #(
  parameter int N_PINS      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              select,
  input  logic [3:0]        wstrb,
  input  logic [5:0]        addr,
  input  logic [31:0]       data_i,
  output logic              ready,
  output logic [31:0]       data_o,
  inout  wire  [N_PINS-1:0] gpio,
  input  logic [N_PINS-1:0] gpio_af_in,
  output logic [N_PINS-1:0] gpio_af_out,
  output logic              irq
);

  function automatic logic [31:0] ones(input int n);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) r[b] = (b < n);
    return r;
  endfunction

  localparam int          N_LO     = (N_PINS > 16) ? 16 : N_PINS;
  localparam logic [31:0] PIN_MASK = ones(N_PINS);
  localparam logic [31:0] MLO_MASK = ones(2 * N_LO);
  localparam logic [31:0] MHI_MASK = ones(2 * (N_PINS - 16));

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  logic [31:0] mode_lo_q;
  logic [31:0] mode_hi_q;
  logic [31:0] out_q;
  logic [31:0] rise_en_q;
  logic [31:0] fall_en_q;
  logic [31:0] pend_q;
  logic        ready_q;
  logic [31:0] rdata_q;

  logic [N_PINS-1:0] sync_q [SYNC_STAGES];
  logic [N_PINS-1:0] prev_q;

  logic        access;
  logic        wr;
  logic        hit_mlo;
  logic        hit_mhi;
  logic        hit_out;
  logic        hit_in;
  logic        hit_set;
  logic        hit_clr;
  logic        hit_re;
  logic        hit_fe;
  logic        hit_pend;
  logic [31:0] rdata;
  logic [31:0] sync_w;
  logic [31:0] prev_w;
  logic [31:0] events;
  logic [31:0] w1c;

  // A held select is ignored on the ready cycle.
  assign access = select & ~ready_q;
  assign wr     = access & (|wstrb);

  assign hit_mlo  = (addr == 6'h00);
  assign hit_mhi  = (addr == 6'h04);
  assign hit_out  = (addr == 6'h08);
  assign hit_in   = (addr == 6'h0C);
  assign hit_set  = (addr == 6'h10);
  assign hit_clr  = (addr == 6'h14);
  assign hit_re   = (addr == 6'h18);
  assign hit_fe   = (addr == 6'h1C);
  assign hit_pend = (addr == 6'h20);

  assign sync_w = 32'(sync_q[SYNC_STAGES-1]);
  assign prev_w = 32'(prev_q);

  assign events = ((sync_w & ~prev_w) & rise_en_q)
                | ((~sync_w & prev_w) & fall_en_q);

  assign w1c = (wr & hit_pend) ? data_i : 32'h0;

  always_comb begin
    rdata = 32'h0;
    unique case (1'b1)
      hit_mlo:  rdata = mode_lo_q;
      hit_mhi:  rdata = mode_hi_q;
      hit_out:  rdata = out_q;
      hit_in:   rdata = sync_w;
      hit_re:   rdata = rise_en_q;
      hit_fe:   rdata = fall_en_q;
      hit_pend: rdata = pend_q;
      default:  rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
    end else if (access) begin
      ready_q <= 1'b1;
      rdata_q <= rdata;
    end else begin
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_lo_q <= 32'h0;
      mode_hi_q <= 32'h0;
      rise_en_q <= 32'h0;
      fall_en_q <= 32'h0;
    end else if (wr) begin
      if (hit_mlo)
        mode_lo_q <= merge(mode_lo_q, data_i, wstrb) & MLO_MASK;
      if (hit_mhi)
        mode_hi_q <= merge(mode_hi_q, data_i, wstrb) & MHI_MASK;
      if (hit_re)
        rise_en_q <= merge(rise_en_q, data_i, wstrb) & PIN_MASK;
      if (hit_fe)
        fall_en_q <= merge(fall_en_q, data_i, wstrb) & PIN_MASK;
    end
  end

  // SET/CLR use the full data word regardless of which strobes are set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= 32'h0;
    end else if (wr) begin
      unique case (1'b1)
        hit_out: out_q <= merge(out_q, data_i, wstrb) & PIN_MASK;
        hit_set: out_q <= out_q | (data_i & PIN_MASK);
        hit_clr: out_q <= out_q & ~data_i;
        default: out_q <= out_q;
      endcase
    end
  end

  // New edges are ORed in after the clear, so a same-cycle edge wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pend_q <= 32'h0;
    else          pend_q <= ((pend_q & ~w1c) | events) & PIN_MASK;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  for (genvar i = 0; i < N_PINS; i++) begin : g_pin
    logic [1:0] m;
    logic       oe;
    logic       dv;
    if (i < 16) begin : g_lo
      assign m = mode_lo_q[2*i +: 2];
    end else begin : g_hi
      assign m = mode_hi_q[2*(i-16) +: 2];
    end
    always_comb begin
      oe = 1'b0;
      dv = 1'b0;
      unique case (m)
        2'b01: begin oe = 1'b1;      dv = out_q[i];      end
        2'b10: begin oe = 1'b1;      dv = gpio_af_in[i]; end
        2'b11: begin oe = ~out_q[i]; dv = 1'b0;          end
        default: begin oe = 1'b0;    dv = 1'b0;          end
      endcase
    end
    assign gpio[i]        = oe ? dv : 1'bz;
    assign gpio_af_out[i] = (m == 2'b10) & gpio[i];
  end

  assign ready  = ready_q;
  assign data_o = rdata_q;
  assign irq    = |pend_q;

endmodule
